// File: rtl/gnr_attractor_ctrl.sv
// Sequencer and Floyd cycle detector for one Boolean GRN instance.
// Steps the node array per initial state and reports attractor records.
module gnr_attractor_ctrl #(
  parameter int N_NODES   = 8,
  parameter int CNT_W     = 16,
  parameter int MAX_STEPS = 1000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [N_NODES-1:0] first_init,
  input  logic [CNT_W-1:0]   num_inits,
  input  logic [N_NODES-1:0] s0_vec,
  input  logic [N_NODES-1:0] s1_vec,
  output logic               reset_nos,
  output logic [N_NODES-1:0] init_vec,
  output logic               start_s0,
  output logic               start_s1,
  output logic               busy,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [N_NODES-1:0] res_init,
  output logic [N_NODES-1:0] res_state,
  output logic [CNT_W-1:0]   res_steps,
  output logic [CNT_W-1:0]   res_period,
  output logic               res_timeout,
  output logic               done
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] LOAD  = 3'd1;
  localparam logic [2:0] STEP  = 3'd2;
  localparam logic [2:0] CMP   = 3'd3;
  localparam logic [2:0] PSTEP = 3'd4;
  localparam logic [2:0] PCMP  = 3'd5;
  localparam logic [2:0] OUT   = 3'd6;

  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_STEPS);
  localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);

  logic [2:0]         state_q, state_d;
  logic [N_NODES-1:0] cur_q, cur_d;
  logic [CNT_W-1:0]   rem_q, rem_d;
  logic [CNT_W-1:0]   step_cnt_q, step_cnt_d;
  logic [CNT_W-1:0]   period_q, period_d;
  logic [N_NODES-1:0] res_state_q, res_state_d;
  logic [CNT_W-1:0]   res_steps_q, res_steps_d;
  logic [CNT_W-1:0]   res_period_q, res_period_d;
  logic               res_timeout_q, res_timeout_d;
  logic               done_q, done_d;

  // Node controls and status decoded from the state register only
  always_comb begin
    reset_nos   = (state_q == LOAD);
    init_vec    = (state_q == LOAD) ? cur_q : '0;
    start_s0    = (state_q == STEP);
    start_s1    = (state_q == STEP) || (state_q == PSTEP);
    busy        = (state_q != IDLE);
    res_valid   = (state_q == OUT);
    res_init    = cur_q;
    res_state   = res_state_q;
    res_steps   = res_steps_q;
    res_period  = res_period_q;
    res_timeout = res_timeout_q;
    done        = done_q;
  end

  // Next-state logic: batch sequencing, Floyd meet search, period count
  always_comb begin
    state_d       = state_q;
    cur_d         = cur_q;
    rem_d         = rem_q;
    step_cnt_d    = step_cnt_q;
    period_d      = period_q;
    res_state_d   = res_state_q;
    res_steps_d   = res_steps_q;
    res_period_d  = res_period_q;
    res_timeout_d = res_timeout_q;
    done_d        = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          cur_d   = first_init;
          rem_d   = (num_inits == '0) ? ONE_C : num_inits;
          state_d = LOAD;
        end
      end
      LOAD: begin
        step_cnt_d    = '0;
        period_d      = '0;
        res_timeout_d = 1'b0;
        state_d       = STEP;
      end
      STEP: begin
        step_cnt_d = step_cnt_q + ONE_C;
        state_d    = CMP;
      end
      CMP: begin
        if (!step_cnt_q[0] && (s0_vec == s1_vec)) begin
          res_state_d = s0_vec;
          res_steps_d = step_cnt_q;
          period_d    = '0;
          state_d     = PSTEP;
        end else if (step_cnt_q == MAX_C) begin
          res_timeout_d = 1'b1;
          res_steps_d   = step_cnt_q;
          state_d       = OUT;
        end else begin
          state_d = STEP;
        end
      end
      PSTEP: begin
        period_d = period_q + ONE_C;
        state_d  = PCMP;
      end
      PCMP: begin
        if (s1_vec == res_state_q) begin
          res_period_d = period_q;
          state_d      = OUT;
        end else if (period_q == MAX_C) begin
          res_timeout_d = 1'b1;
          res_period_d  = period_q;
          state_d       = OUT;
        end else begin
          state_d = PSTEP;
        end
      end
      OUT: begin
        if (res_ready) begin
          if (rem_q == ONE_C) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            rem_d   = rem_q - ONE_C;
            cur_d   = cur_q + 1'b1;
            state_d = LOAD;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and result registers; reset abandons any run in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      cur_q         <= '0;
      rem_q         <= '0;
      step_cnt_q    <= '0;
      period_q      <= '0;
      res_state_q   <= '0;
      res_steps_q   <= '0;
      res_period_q  <= '0;
      res_timeout_q <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cur_q         <= cur_d;
      rem_q         <= rem_d;
      step_cnt_q    <= step_cnt_d;
      period_q      <= period_d;
      res_state_q   <= res_state_d;
      res_steps_q   <= res_steps_d;
      res_period_q  <= res_period_d;
      res_timeout_q <= res_timeout_d;
      done_q        <= done_d;
    end
  end

endmodule

// File: tb/tb_gnr_attractor_ctrl.sv
// Bench for gnr_attractor_ctrl with behavioural node arrays.
// Table vectors plus a scoreboard of expected result records.
module tb_gnr_attractor_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // DUT A: 3 nodes, default limits
  logic        start_a = 1'b0;
  logic [2:0]  first_init_a = '0;
  logic [15:0] num_inits_a = '0;
  logic [2:0]  s0_a, s1_a;
  logic        reset_nos_a, start_s0_a, start_s1_a, busy_a;
  logic [2:0]  init_vec_a, res_init_a, res_state_a;
  logic        res_valid_a, res_timeout_a, done_a;
  logic        res_ready_a = 1'b0;
  logic [15:0] res_steps_a, res_period_a;

  gnr_attractor_ctrl #(.N_NODES(3), .CNT_W(16), .MAX_STEPS(1000)) u_dut_a (
    .clk(clk), .rst(rst), .start(start_a),
    .first_init(first_init_a), .num_inits(num_inits_a),
    .s0_vec(s0_a), .s1_vec(s1_a),
    .reset_nos(reset_nos_a), .init_vec(init_vec_a),
    .start_s0(start_s0_a), .start_s1(start_s1_a),
    .busy(busy_a), .res_valid(res_valid_a), .res_ready(res_ready_a),
    .res_init(res_init_a), .res_state(res_state_a),
    .res_steps(res_steps_a), .res_period(res_period_a),
    .res_timeout(res_timeout_a), .done(done_a)
  );

  // DUT B: 4-node increment net with a tight step limit
  logic        start_b = 1'b0;
  logic [3:0]  first_init_b = 4'b0101;
  logic [15:0] num_inits_b = 16'd1;
  logic [3:0]  s0_b, s1_b;
  logic        reset_nos_b, start_s0_b, start_s1_b, busy_b;
  logic [3:0]  init_vec_b, res_init_b, res_state_b;
  logic        res_valid_b, res_timeout_b, done_b;
  logic        res_ready_b = 1'b1;
  logic [15:0] res_steps_b, res_period_b;

  gnr_attractor_ctrl #(.N_NODES(4), .CNT_W(16), .MAX_STEPS(8)) u_dut_b (
    .clk(clk), .rst(rst), .start(start_b),
    .first_init(first_init_b), .num_inits(num_inits_b),
    .s0_vec(s0_b), .s1_vec(s1_b),
    .reset_nos(reset_nos_b), .init_vec(init_vec_b),
    .start_s0(start_s0_b), .start_s1(start_s1_b),
    .busy(busy_b), .res_valid(res_valid_b), .res_ready(res_ready_b),
    .res_init(res_init_b), .res_state(res_state_b),
    .res_steps(res_steps_b), .res_period(res_period_b),
    .res_timeout(res_timeout_b), .done(done_b)
  );

  // Network functions: 0 = rotate left, 1 = shift right
  int net_sel = 0;
  function automatic logic [2:0] fa(input logic [2:0] x, input int sel);
    if (sel == 0) return {x[1:0], x[2]};
    return {1'b0, x[2:1]};
  endfunction

  // Node arrays: hare steps every start_s1, tortoise every 2nd start_s0
  logic [2:0] hare_a = '0, tort_a = '0;
  logic       pass_a = 1'b0;
  logic [3:0] hare_b = '0, tort_b = '0;
  logic       pass_b = 1'b0;
  assign s0_a = tort_a;
  assign s1_a = hare_a;
  assign s0_b = tort_b;
  assign s1_b = hare_b;

  always @(posedge clk) begin
    if (reset_nos_a) begin
      hare_a <= init_vec_a;
      tort_a <= init_vec_a;
      pass_a <= 1'b1;
    end else begin
      if (start_s1_a) hare_a <= fa(hare_a, net_sel);
      if (start_s0_a) begin
        if (pass_a) pass_a <= 1'b0;
        else begin
          tort_a <= fa(tort_a, net_sel);
          pass_a <= 1'b1;
        end
      end
    end
  end

  always @(posedge clk) begin
    if (reset_nos_b) begin
      hare_b <= init_vec_b;
      tort_b <= init_vec_b;
      pass_b <= 1'b1;
    end else begin
      if (start_s1_b) hare_b <= hare_b + 4'd1;
      if (start_s0_b) begin
        if (pass_b) pass_b <= 1'b0;
        else begin
          tort_b <= tort_b + 4'd1;
          pass_b <= 1'b1;
        end
      end
    end
  end

  // Bookkeeping
  int chk_cnt = 0;
  int pass_cnt = 0;
  int rec_cnt = 0;
  int exp_rec = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  typedef struct {
    logic [2:0]  init;
    logic [2:0]  state;
    logic [15:0] steps;
    logic [15:0] period;
    logic        timeout;
    logic        last;
  } rec_t;
  rec_t sb[$];

  // Independent Floyd model over the software network function
  function automatic rec_t model(input logic [2:0] init, input int sel);
    rec_t r;
    logic [2:0] t, h;
    bit found;
    int p;
    r.init = init;
    r.timeout = 1'b0;
    r.last = 1'b0;
    r.steps = '0;
    t = init;
    h = init;
    found = 0;
    for (int i = 1; i <= 500; i++) begin
      if (!found) begin
        t = fa(t, sel);
        h = fa(fa(h, sel), sel);
        if (t == h) begin
          found = 1;
          r.steps = 16'(2 * i);
        end
      end
    end
    r.state = t;
    p = 0;
    h = t;
    for (int i = 0; i < 16; i++) begin
      if (i == 0 || h != t) begin
        h = fa(h, sel);
        p++;
      end
    end
    r.period = 16'(p);
    return r;
  endfunction

  // Ready driver: hold ready low for stall_n valid cycles per record
  int stall_n = 0;
  initial begin
    int vcnt;
    vcnt = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!res_valid_a) vcnt = 0;
      else vcnt++;
      if (stall_n == 0) res_ready_a = 1'b1;
      else res_ready_a = res_valid_a && (vcnt > stall_n);
    end
  end

  // Monitor: pop and compare records, watch load, stall and done
  initial begin
    rec_t e;
    logic [40:0] snap, now;
    bit prev_wait, stall_bad, exp_done;
    prev_wait = 0;
    stall_bad = 0;
    exp_done = 0;
    snap = '0;
    forever begin
      @(negedge clk);
      if (exp_done) begin
        chk("done_pulse", 64'(done_a), 64'd1);
        exp_done = 0;
      end else if (done_a) begin
        chk("done_spurious", 64'(done_a), 64'd0);
      end
      if (reset_nos_a && sb.size() > 0) begin
        chk("init_vec", 64'(init_vec_a), 64'(sb[0].init));
        chk("load_ctrl", 64'({start_s0_a, start_s1_a}), 64'd0);
      end
      now = {res_init_a, res_state_a, res_steps_a,
             res_period_a, res_timeout_a};
      if (res_valid_a) begin
        if (prev_wait && now != snap) stall_bad = 1;
        snap = now;
        if (res_ready_a) begin
          if (sb.size() == 0) begin
            chk_cnt++;
            $display("FAIL unexpected_record: init %0h", res_init_a);
          end else begin
            e = sb.pop_front();
            chk("res_init", 64'(res_init_a), 64'(e.init));
            chk("res_state", 64'(res_state_a), 64'(e.state));
            chk("res_steps", 64'(res_steps_a), 64'(e.steps));
            chk("res_period", 64'(res_period_a), 64'(e.period));
            chk("res_timeout", 64'(res_timeout_a), 64'(e.timeout));
            chk("stall_stable", 64'(stall_bad), 64'd0);
            if (e.last) exp_done = 1;
          end
          stall_bad = 0;
          rec_cnt++;
          prev_wait = 0;
        end else begin
          prev_wait = 1;
        end
      end else begin
        prev_wait = 0;
      end
    end
  end

  task automatic run_batch(input int net, input logic [2:0] first,
                           input logic [15:0] n, input int stall,
                           input bit poke);
    bit got;
    net_sel = net;
    stall_n = stall;
    first_init_a = first;
    num_inits_a = n;
    start_a = 1'b1;
    @(posedge clk);
    #1;
    start_a = 1'b0;
    chk("busy_after_start", 64'(busy_a), 64'd1);
    if (poke) begin
      repeat (4) @(posedge clk);
      #1;
      first_init_a = 3'b111;
      num_inits_a = 16'd3;
      start_a = 1'b1;
      @(posedge clk);
      #1;
      start_a = 1'b0;
    end
    got = 0;
    for (int i = 0; i < 3000; i++) begin
      if (!got) begin
        @(posedge clk);
        #1;
        if (done_a) got = 1;
      end
    end
    chk("batch_done_seen", 64'(got), 64'd1);
  endtask

  typedef struct {
    int          net;
    logic [2:0]  first;
    logic [15:0] n;
    int          stall;
    bit          poke;
    logic [2:0]  e_state;
    logic [15:0] e_steps;
    logic [15:0] e_period;
  } vec_t;
  vec_t vt[8];

  initial begin
    rec_t r;
    bit got;
    int steps, psteps;
    logic [2:0] x;

    vt[0] = '{0, 3'b001, 16'd1, 0, 0, 3'b001, 16'd6, 16'd3};
    vt[1] = '{0, 3'b000, 16'd1, 0, 0, 3'b000, 16'd2, 16'd1};
    vt[2] = '{0, 3'b111, 16'd1, 0, 0, 3'b111, 16'd2, 16'd1};
    vt[3] = '{0, 3'b011, 16'd0, 2, 0, 3'b011, 16'd6, 16'd3};
    vt[4] = '{1, 3'b100, 16'd1, 0, 0, 3'b000, 16'd6, 16'd1};
    vt[5] = '{1, 3'b010, 16'd1, 0, 0, 3'b000, 16'd4, 16'd1};
    vt[6] = '{1, 3'b111, 16'd1, 1, 0, 3'b000, 16'd6, 16'd1};
    vt[7] = '{0, 3'b001, 16'd1, 0, 1, 3'b001, 16'd6, 16'd3};

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs_a", {16'd0, reset_nos_a, init_vec_a, start_s0_a,
        start_s1_a, busy_a, res_valid_a, res_init_a, res_state_a,
        res_steps_a, res_period_a, res_timeout_a, done_a}, 64'd0);
    chk("reset_outputs_b", {12'd0, reset_nos_b, init_vec_b, start_s0_b,
        start_s1_b, busy_b, res_valid_b, res_init_b, res_state_b,
        res_steps_b, res_period_b, res_timeout_b, done_b}, 64'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int v = 0; v < 8; v++) begin
      r.init = vt[v].first;
      r.state = vt[v].e_state;
      r.steps = vt[v].e_steps;
      r.period = vt[v].e_period;
      r.timeout = 1'b0;
      r.last = 1'b1;
      sb.push_back(r);
      exp_rec++;
      run_batch(vt[v].net, vt[v].first, vt[v].n,
                vt[v].stall, vt[v].poke);
    end

    for (int k = 0; k < 4; k++) begin
      x = 3'b110 + 3'(k);
      r = model(x, 0);
      r.last = (k == 3);
      sb.push_back(r);
      exp_rec++;
    end
    run_batch(0, 3'b110, 16'd4, 5, 0);

    net_sel = 0;
    stall_n = 0;
    first_init_a = 3'b001;
    num_inits_a = 16'd1;
    start_a = 1'b1;
    @(posedge clk);
    #1;
    start_a = 1'b0;
    got = 0;
    for (int i = 0; i < 200; i++) begin
      if (!got) begin
        @(posedge clk);
        #1;
        if (start_s1_a && !start_s0_a) got = 1;
      end
    end
    chk("reach_pstep", 64'(got), 64'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_mid_outputs", {16'd0, reset_nos_a, init_vec_a, start_s0_a,
        start_s1_a, busy_a, res_valid_a, res_init_a, res_state_a,
        res_steps_a, res_period_a, res_timeout_a, done_a}, 64'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_no_done", 64'({busy_a, done_a}), 64'd0);
    r = model(3'b001, 0);
    r.last = 1'b1;
    sb.push_back(r);
    exp_rec++;
    run_batch(0, 3'b001, 16'd1, 0, 0);

    start_b = 1'b1;
    @(posedge clk);
    #1;
    start_b = 1'b0;
    steps = 0;
    psteps = 0;
    got = 0;
    for (int i = 0; i < 200; i++) begin
      if (!got) begin
        @(posedge clk);
        #1;
        if (start_s0_b) steps++;
        if (start_s1_b && !start_s0_b) psteps++;
        if (res_valid_b) got = 1;
      end
    end
    chk("b_valid_seen", 64'(got), 64'd1);
    chk("b_timeout", 64'(res_timeout_b), 64'd1);
    chk("b_res_steps", 64'(res_steps_b), 64'd8);
    chk("b_step_pulses", 64'(steps), 64'd8);
    chk("b_no_pstep", 64'(psteps), 64'd0);
    chk("b_res_init", 64'(res_init_b), 64'(4'b0101));
    @(posedge clk);
    #1;
    chk("b_done", 64'({done_b, busy_b}), 64'b10);

    repeat (4) @(posedge clk);
    #1;
    chk("record_count", 64'(rec_cnt), 64'(exp_rec));
    chk("sb_empty", 64'(sb.size()), 64'd0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
